// File: rtl/chu_gpo_seq_if.sv
// chu_gpo_seq_if
// MMIO slot bus bundle for the pattern-sequencer GPO core.
//   cs      : slot select
//   read    : read strobe (reads have no side effects)
//   write   : write strobe
//   addr    : 5-bit register word address
//   wr_data : 32-bit write data
//   rd_data : 32-bit read data, combinational from addr
interface chu_gpo_seq_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_gpo_seq.sv
// chu_gpo_seq
// MMIO slot core driving a W-bit output port from a programmable pattern
// table. Software loads up to DEPTH patterns, a dwell period and a sequence
// length, then starts the sequencer, which steps once or loops.
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset
//   bus       : slot bus (slave side), see chu_gpo_seq_if
//   dout      : registered external output port
//   busy      : high while the sequencer is running
//   done_tick : one-cycle pulse when a non-looping sequence completes
// Register map (word address):
//   0  CTRL write {loop, stop, start} / STATUS read {idx[7:4], loop, busy}
//   1  PERIOD     2  LEN     3  DOUT     16.. PAT[0..DEPTH-1]
module chu_gpo_seq #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int PW    = 32
) (
  input  logic         clk,
  input  logic         reset,
  chu_gpo_seq_if.slave bus,
  output logic [W-1:0] dout,
  output logic         busy,
  output logic         done_tick
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [PW-1:0] cnt, cnt_next;
  logic [W-1:0]  dout_next;
  logic          done_next;

  logic [PW-1:0] period;
  logic [4:0]    len;
  logic          loop;
  logic [W-1:0]  pat [DEPTH];

  logic          wr_en, ctrl_wr, period_wr, len_wr, dout_wr, pat_wr, pat_hit;
  logic          start, stop;
  logic [IW-1:0] pat_sel;
  logic [PW-1:0] peff_m1;
  logic [4:0]    leff;
  logic          at_last;
  logic [31:0]   rd;
  logic          unused_read;

  // Register decode; reads never have side effects, so the read strobe is
  // only acknowledged here.
  assign unused_read = bus.read;
  assign wr_en     = bus.cs && bus.write;
  assign ctrl_wr   = wr_en && (bus.addr == 5'd0);
  assign period_wr = wr_en && (bus.addr == 5'd1);
  assign len_wr    = wr_en && (bus.addr == 5'd2);
  assign dout_wr   = wr_en && (bus.addr == 5'd3);
  assign pat_hit   = bus.addr[4] && ({1'b0, bus.addr[3:0]} < 5'(DEPTH));
  assign pat_wr    = wr_en && pat_hit;
  assign pat_sel   = bus.addr[IW-1:0];
  assign start     = bus.wr_data[0];
  assign stop      = bus.wr_data[1];

  // Effective period and length: zero behaves as one, length clamps to the
  // table size. The stored values stay raw so software reads back what it
  // wrote.
  assign peff_m1 = (period == '0) ? '0 : period - PW'(1);
  assign leff    = (len == 5'd0) ? 5'd1 :
                   (len > 5'(DEPTH)) ? 5'(DEPTH) : len;
  // A >= compare so that shrinking LEN mid-run still ends at the next step.
  assign at_last = (5'(idx) >= leff - 5'd1);

  assign busy = (state == RUN);

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= PW'(1);
      len    <= 5'd1;
      loop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
    end else begin
      if (period_wr) period <= bus.wr_data[PW-1:0];
      if (len_wr)    len    <= bus.wr_data[4:0];
      if (ctrl_wr)   loop   <= bus.wr_data[2];
      if (pat_wr)    pat[pat_sel] <= bus.wr_data[W-1:0];
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      dout      <= '0;
      done_tick <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      cnt       <= cnt_next;
      dout      <= dout_next;
      done_tick <= done_next;
    end
  end

  // Next-state logic. Stop beats start in the same CTRL write; a start while
  // running restarts from entry 0. PAT writes only show on dout when that
  // entry is next loaded, since dout is only reloaded at step boundaries.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    dout_next  = dout;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_wr && start && !stop) begin
          state_next = RUN;
          idx_next   = '0;
          cnt_next   = '0;
          dout_next  = pat[0];
        end else if (dout_wr) begin
          dout_next = bus.wr_data[W-1:0];
        end
      end
      RUN: begin
        if (ctrl_wr && stop) begin
          state_next = IDLE;
        end else if (ctrl_wr && start) begin
          idx_next  = '0;
          cnt_next  = '0;
          dout_next = pat[0];
        end else if (cnt != peff_m1) begin
          cnt_next = cnt + PW'(1);
        end else begin
          cnt_next = '0;
          if (!at_last) begin
            idx_next  = idx + IW'(1);
            dout_next = pat[idx + IW'(1)];
          end else if (loop) begin
            idx_next  = '0;
            dout_next = pat[0];
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read mux, combinational from the address; unmapped addresses read 0.
  always_comb begin
    rd = '0;
    case (bus.addr)
      5'd0: rd = {24'd0, 4'(idx), 2'b00, loop, busy};
      5'd1: rd[PW-1:0] = period;
      5'd2: rd[4:0] = len;
      5'd3: rd[W-1:0] = dout;
      default: if (pat_hit) rd[W-1:0] = pat[pat_sel];
    endcase
  end

  assign bus.rd_data = rd;

endmodule

// File: tb/tb_chu_gpo_seq.sv
// tb_chu_gpo_seq
// Self-checking bench for chu_gpo_seq: a register table exercised in a loop,
// then scoreboarded run sequences whose expected per-cycle outputs come from
// a simple trajectory model of the pattern table.
module tb_chu_gpo_seq;
  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chu_gpo_seq_if bus ();
  logic [W-1:0] dout;
  logic         busy;
  logic         done_tick;

  chu_gpo_seq #(.W(W), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dout      (dout),
    .busy      (busy),
    .done_tick (done_tick)
  );

  typedef struct {
    logic [4:0]  addr;
    logic        doWrite;
    logic [31:0] wdata;
    logic [31:0] expRd;
  } vec_t;

  typedef struct {
    logic [W-1:0] dout;
    logic         busy;
    logic         done;
  } exp_t;

  int           passCount = 0;
  int           checkCount = 0;
  exp_t         expQ[$];
  logic [W-1:0] patModel [DEPTH];
  vec_t         vecs [16];

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One bus write, committed on the next rising edge; returns 1 ns after it.
  task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
    bus.cs      = 1'b1;
    bus.write   = 1'b1;
    bus.read    = 1'b0;
    bus.addr    = a;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.cs    = 1'b0;
    bus.write = 1'b0;
  endtask

  // Combinational read, sampled mid-cycle.
  task automatic busRead(input logic [4:0] a, output logic [31:0] d);
    bus.cs   = 1'b1;
    bus.read = 1'b1;
    bus.addr = a;
    #1;
    d = bus.rd_data;
    bus.cs   = 1'b0;
    bus.read = 1'b0;
  endtask

  // Apply one table vector: optional write, then read back and compare.
  task automatic applyStimulus(input int n, input vec_t v);
    logic [31:0] r;
    if (v.doWrite) busWrite(v.addr, v.wdata);
    busRead(v.addr, r);
    checkOutput($sformatf("vec%0d addr%0d", n, v.addr), r, v.expRd);
  endtask

  function automatic exp_t mkExp(input logic [W-1:0] d, input logic b, input logic t);
    exp_t e;
    e.dout = d;
    e.busy = b;
    e.done = t;
    return e;
  endfunction

  // Expected outputs sampled after each edge from the start edge on.
  task automatic pushRun(input int leff, input int peff, input bit loopOn, input int nCycles);
    if (!loopOn) begin
      for (int k = 0; k < leff; k++)
        for (int p = 0; p < peff; p++) expQ.push_back(mkExp(patModel[k], 1'b1, 1'b0));
      expQ.push_back(mkExp(patModel[leff-1], 1'b0, 1'b1));
      expQ.push_back(mkExp(patModel[leff-1], 1'b0, 1'b0));
    end else begin
      for (int c = 0; c < nCycles; c++)
        expQ.push_back(mkExp(patModel[(c / peff) % leff], 1'b1, 1'b0));
    end
  endtask

  // Pop and compare one expected record per cycle until the queue drains.
  task automatic checkQueue(input string name);
    exp_t e;
    int   n = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput($sformatf("%s dout c%0d", name, n), 32'(dout), 32'(e.dout));
      checkOutput($sformatf("%s busy c%0d", name, n), 32'(busy), 32'(e.busy));
      checkOutput($sformatf("%s done c%0d", name, n), 32'(done_tick), 32'(e.done));
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] r;

    vecs[0]  = '{addr: 5'd0,  doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h0};
    vecs[1]  = '{addr: 5'd1,  doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h1};
    vecs[2]  = '{addr: 5'd2,  doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h1};
    vecs[3]  = '{addr: 5'd3,  doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h0};
    vecs[4]  = '{addr: 5'd16, doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h0};
    vecs[5]  = '{addr: 5'd23, doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h0};
    vecs[6]  = '{addr: 5'd8,  doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h0};
    vecs[7]  = '{addr: 5'd24, doWrite: 1'b0, wdata: 32'h0,        expRd: 32'h0};
    vecs[8]  = '{addr: 5'd1,  doWrite: 1'b1, wdata: 32'h0,        expRd: 32'h0};
    vecs[9]  = '{addr: 5'd2,  doWrite: 1'b1, wdata: 32'd20,       expRd: 32'd20};
    vecs[10] = '{addr: 5'd2,  doWrite: 1'b1, wdata: 32'hFFFFFFFF, expRd: 32'h1F};
    vecs[11] = '{addr: 5'd17, doWrite: 1'b1, wdata: 32'h1FF,      expRd: 32'hFF};
    vecs[12] = '{addr: 5'd8,  doWrite: 1'b1, wdata: 32'h1234,     expRd: 32'h0};
    vecs[13] = '{addr: 5'd31, doWrite: 1'b1, wdata: 32'hFFFFFFFF, expRd: 32'h0};
    vecs[14] = '{addr: 5'd0,  doWrite: 1'b1, wdata: 32'h4,        expRd: 32'h2};
    vecs[15] = '{addr: 5'd0,  doWrite: 1'b1, wdata: 32'h0,        expRd: 32'h0};

    for (int i = 0; i < DEPTH; i++) patModel[i] = '0;
    patModel[0] = 8'h11; patModel[1] = 8'h22; patModel[2] = 8'h33; patModel[3] = 8'h44;

    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset dout", 32'(dout), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done_tick), 32'h0);

    $display("[TB] register table");
    for (int i = 0; i < 16; i++) applyStimulus(i, vecs[i]);

    $display("[TB] one-shot sequence");
    for (int k = 0; k < 4; k++) busWrite(5'(16 + k), 32'(patModel[k]));
    busWrite(5'd1, 32'd3);
    busWrite(5'd2, 32'd4);
    busWrite(5'd0, 32'h1);
    pushRun(4, 3, 1'b0, 0);
    checkQueue("oneshot");

    $display("[TB] looping sequence and stop");
    busWrite(5'd0, 32'h5);
    pushRun(4, 3, 1'b1, 14);
    checkQueue("loop");
    busWrite(5'd0, 32'h2);
    for (int i = 0; i < 3; i++) expQ.push_back(mkExp(8'h11, 1'b0, 1'b0));
    checkQueue("stop");

    $display("[TB] zero period and length, clamped length");
    busWrite(5'd1, 32'd0);
    busWrite(5'd2, 32'd0);
    busWrite(5'd0, 32'h1);
    pushRun(1, 1, 1'b0, 0);
    checkQueue("minimal");
    for (int k = 4; k < DEPTH; k++) begin
      patModel[k] = 8'(8'h11 * (k + 1));
      busWrite(5'(16 + k), 32'(patModel[k]));
    end
    busWrite(5'd1, 32'd1);
    busWrite(5'd2, 32'd20);
    busWrite(5'd0, 32'h5);
    pushRun(DEPTH, 1, 1'b1, 10);
    checkQueue("clamp");
    busWrite(5'd0, 32'h2);
    expQ.push_back(mkExp(patModel[2], 1'b0, 1'b0));
    checkQueue("clampstop");

    $display("[TB] direct output writes");
    busWrite(5'd3, 32'hA5);
    checkOutput("dout write idle", 32'(dout), 32'hA5);
    busRead(5'd3, r);
    checkOutput("dout readback", r, 32'hA5);
    busWrite(5'd0, 32'h3);
    checkOutput("start+stop idle busy", 32'(busy), 32'h0);
    checkOutput("start+stop idle dout", 32'(dout), 32'hA5);
    busWrite(5'd1, 32'd3);
    busWrite(5'd2, 32'd4);
    busWrite(5'd0, 32'h1);
    checkOutput("run start dout", 32'(dout), 32'h11);
    busWrite(5'd3, 32'h5A);
    checkOutput("dout write run ignored", 32'(dout), 32'h11);
    checkOutput("dout write run busy", 32'(busy), 32'h1);
    busWrite(5'd0, 32'h3);
    checkOutput("start+stop run busy", 32'(busy), 32'h0);
    checkOutput("start+stop run dout", 32'(dout), 32'h11);
    checkOutput("start+stop run done", 32'(done_tick), 32'h0);

    $display("[TB] reset mid-run");
    busWrite(5'd0, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    busRead(5'd0, r);
    checkOutput("status idx2", r, 32'h21);
    checkOutput("dout idx2", 32'(dout), 32'h33);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset dout", 32'(dout), 32'h0);
    checkOutput("midreset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    busRead(5'd1, r);
    checkOutput("midreset period", r, 32'h1);
    busRead(5'd2, r);
    checkOutput("midreset len", r, 32'h1);
    busRead(5'd16, r);
    checkOutput("midreset pat0", r, 32'h0);
    busRead(5'd0, r);
    checkOutput("midreset status", r, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
